// File: rtl/corelet_seq_ctrl.sv
// Sequencer for one systolic corelet. For each kernel offset (kij) it loads
// ROW weight words into the array, streams cfg_nact activations through it,
// drains the OFIFO psums into PMEM, then clears the array weights.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for seq_begin; illegal configuration reports cfg_err
// S_W_LOAD  | W SRAM -> L0 reads, one weight word per cycle, stalls on l0_full
// S_W_FLUSH | last weight word lands in L0 (SRAM read latency)
// S_W_KERN  | L0 -> array kernel load, ROW cycles, paused while !l0_ready
// S_W_WAIT  | COL idle cycles so weights settle across the columns
// S_A_LOAD  | ACT SRAM -> L0 reads, cfg_nact words, stalls on l0_full
// S_A_FLUSH | last activation lands in L0
// S_A_EXEC  | L0 -> array execute, cfg_nact cycles, paused while !l0_ready
// S_DRAIN   | waiting for the remaining psum rows, bounded by a timeout
// S_CLEAR   | one-cycle weight clear, then next kij or finish
// S_DONE    | one-cycle seq_done pulse

module corelet_seq_ctrl #(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int MAX_KIJ = 9,
   parameter int MAX_ACT = 64,
   parameter int A_AW    = 7,
   parameter int OP_AW   = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seq_begin,
   input  logic             abort,
   input  logic [3:0]       cfg_kij,
   input  logic [6:0]       cfg_nact,
   input  logic [OP_AW-1:0] cfg_op_base,
   output logic             busy,
   output logic             seq_done,
   output logic             cfg_err,
   output logic [A_AW-1:0]  act_addr,
   output logic [A_AW-1:0]  w_addr,
   output logic             act_cen,
   output logic             w_cen,
   output logic             aw_sel,
   output logic             l0_wr,
   output logic             l0_rd,
   input  logic             l0_full,
   input  logic             l0_ready,
   output logic [1:0]       inst_w,
   output logic             array_clr,
   input  logic             ofifo_valid,
   output logic             ofifo_rd,
   output logic [OP_AW-1:0] op_addr,
   output logic             op_cen,
   output logic             op_wen
);

   localparam int TW = $clog2(ROW + COL + MAX_ACT + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_LOAD,
      S_W_FLUSH,
      S_W_KERN,
      S_W_WAIT,
      S_A_LOAD,
      S_A_FLUSH,
      S_A_EXEC,
      S_DRAIN,
      S_CLEAR,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       kij_q, kij_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [6:0]       ocnt_q, ocnt_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [3:0]       kij_cfg_q, kij_cfg_d;
   logic [6:0]       nact_q, nact_d;
   logic [OP_AW-1:0] base_q, base_d;
   logic             l0_wr_q, l0_wr_d;
   logic             cfg_err_q, cfg_err_d;
   logic             abort_clr_q, abort_clr_d;

   logic             cfg_legal;
   logic             drain_en;
   logic [A_AW-1:0]  w_base;
   logic [OP_AW-1:0] op_row_base;

   assign cfg_legal   = (cfg_kij != 4'd0) && (cfg_kij <= 4'(MAX_KIJ)) &&
                        (cfg_nact != 7'd0) && (cfg_nact <= 7'(MAX_ACT));
   assign drain_en    = ((state_q == S_A_EXEC) || (state_q == S_DRAIN)) &&
                        ofifo_valid && (ocnt_q != nact_q);
   assign w_base      = A_AW'(kij_q * ROW);
   assign op_row_base = base_q + OP_AW'(kij_q) * OP_AW'(nact_q);

   assign busy     = (state_q != S_IDLE);
   assign l0_wr    = l0_wr_q;
   assign cfg_err  = cfg_err_q;

   // Next-state, counter updates and all per-state strobes.
   always_comb begin
      state_d     = state_q;
      kij_d       = kij_q;
      cnt_d       = cnt_q;
      ocnt_d      = ocnt_q;
      tmr_d       = tmr_q;
      kij_cfg_d   = kij_cfg_q;
      nact_d      = nact_q;
      base_d      = base_q;
      cfg_err_d   = 1'b0;
      abort_clr_d = 1'b0;
      l0_wr_d     = 1'b0;

      w_cen     = 1'b1;
      act_cen   = 1'b1;
      w_addr    = '0;
      act_addr  = '0;
      aw_sel    = 1'b0;
      l0_rd     = 1'b0;
      inst_w    = 2'b00;
      array_clr = abort_clr_q;
      seq_done  = 1'b0;
      ofifo_rd  = 1'b0;
      op_cen    = 1'b1;
      op_wen    = 1'b1;
      op_addr   = '0;

      // Psum rows are popped whenever they show up during execute or drain;
      // popping stops once the expected row count for this kij is reached.
      if (drain_en) begin
         ofifo_rd = 1'b1;
         op_cen   = 1'b0;
         op_wen   = 1'b0;
         op_addr  = op_row_base + OP_AW'(ocnt_q);
         ocnt_d   = ocnt_q + 7'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (seq_begin) begin
               if (cfg_legal) begin
                  kij_cfg_d = cfg_kij;
                  nact_d    = cfg_nact;
                  base_d    = cfg_op_base;
                  kij_d     = 4'd0;
                  cnt_d     = 7'd0;
                  ocnt_d    = 7'd0;
                  state_d   = S_W_LOAD;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_W_LOAD: begin
            aw_sel = 1'b1;
            w_addr = w_base + A_AW'(cnt_q);
            if (!l0_full) begin
               w_cen = 1'b0;
               if (cnt_q == 7'(ROW - 1)) begin
                  cnt_d   = 7'd0;
                  state_d = S_W_FLUSH;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_W_FLUSH: begin
            aw_sel  = 1'b1;
            cnt_d   = 7'd0;
            state_d = S_W_KERN;
         end
         S_W_KERN: begin
            if (l0_ready) begin
               l0_rd  = 1'b1;
               inst_w = 2'b01;
               if (cnt_q == 7'(ROW - 1)) begin
                  cnt_d   = 7'd0;
                  tmr_d   = TW'(COL);
                  state_d = S_W_WAIT;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_W_WAIT: begin
            if (tmr_q <= TW'(1)) begin
               cnt_d   = 7'd0;
               state_d = S_A_LOAD;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_A_LOAD: begin
            act_addr = A_AW'(cnt_q);
            if (!l0_full) begin
               act_cen = 1'b0;
               if (cnt_q == nact_q - 7'd1) begin
                  cnt_d   = 7'd0;
                  state_d = S_A_FLUSH;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_A_FLUSH: begin
            cnt_d   = 7'd0;
            state_d = S_A_EXEC;
         end
         S_A_EXEC: begin
            if (l0_ready) begin
               l0_rd  = 1'b1;
               inst_w = 2'b10;
               if (cnt_q == nact_q - 7'd1) begin
                  cnt_d   = 7'd0;
                  tmr_d   = TW'(ROW + COL) + TW'(nact_q);
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_DRAIN: begin
            if (ocnt_q == nact_q) begin
               state_d = S_CLEAR;
            end else if (tmr_q <= TW'(1)) begin
               cfg_err_d = 1'b1;
               tmr_d     = '0;
               state_d   = S_IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_CLEAR: begin
            array_clr = 1'b1;
            if (kij_q == kij_cfg_q - 4'd1) begin
               state_d = S_DONE;
            end else begin
               kij_d   = kij_q + 4'd1;
               ocnt_d  = 7'd0;
               cnt_d   = 7'd0;
               state_d = S_W_LOAD;
            end
         end
         S_DONE: begin
            seq_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // An SRAM read issued this cycle becomes an L0 write next cycle.
      l0_wr_d = !w_cen || !act_cen;

      // Abort beats every transition, including a start in IDLE. The array is
      // cleared once on the way out unless CLEAR is already doing it.
      if (abort) begin
         state_d     = S_IDLE;
         kij_d       = 4'd0;
         cnt_d       = 7'd0;
         ocnt_d      = 7'd0;
         tmr_d       = '0;
         kij_cfg_d   = kij_cfg_q;
         nact_d      = nact_q;
         base_d      = base_q;
         l0_wr_d     = 1'b0;
         cfg_err_d   = 1'b0;
         abort_clr_d = (state_q != S_IDLE) && (state_q != S_CLEAR);
      end
   end

   // State, counters and latched configuration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         kij_q       <= 4'd0;
         cnt_q       <= 7'd0;
         ocnt_q      <= 7'd0;
         tmr_q       <= '0;
         kij_cfg_q   <= 4'd0;
         nact_q      <= 7'd0;
         base_q      <= '0;
         l0_wr_q     <= 1'b0;
         cfg_err_q   <= 1'b0;
         abort_clr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kij_q       <= kij_d;
         cnt_q       <= cnt_d;
         ocnt_q      <= ocnt_d;
         tmr_q       <= tmr_d;
         kij_cfg_q   <= kij_cfg_d;
         nact_q      <= nact_d;
         base_q      <= base_d;
         l0_wr_q     <= l0_wr_d;
         cfg_err_q   <= cfg_err_d;
         abort_clr_q <= abort_clr_d;
      end
   end

endmodule
